divisor_seq: RTL and testbench

DIVISOR_SEQ -- requirements
Module: divisor_seq

---
 rtl/divisor_seq.sv | 123 ++++++++++++
 tb/tb_divisor_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/divisor_seq.sv
// Sequential restoring divider: one quotient bit per clock, fixed WIDTH+1 cycle latency.
// Supports unsigned and two's-complement operands with divide-by-zero flagging.
module divisor_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dmag;
    logic [WIDTH-1:0] dvd_raw;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   trial;
    logic             last_step;

    always_comb begin
        a_mag     = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
        b_mag     = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
        // Shifted partial remainder is WIDTH+1 bits; MSB of the difference is the borrow.
        trial     = {rem, quo[WIDTH-1]} - {1'b0, dmag};
        last_step = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = (state != IDLE);
        case (state)
            IDLE:    if (start) state_nx = CALC;
            CALC:    if (last_step) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            rem         <= '0;
            quo         <= '0;
            dmag        <= '0;
            dvd_raw     <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt     <= '0;
                        rem     <= '0;
                        quo     <= a_mag;
                        dmag    <= b_mag;
                        dvd_raw <= dividend;
                        neg_q   <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r   <= signed_op & dividend[WIDTH-1];
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (!trial[WIDTH]) begin
                        rem <= trial[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                end
                FIX: begin
                    done <= 1'b1;
                    // A zero divisor bypasses sign fix-up so the raw dividend is reported.
                    if (dmag == '0) begin
                        quotient    <= '1;
                        remainder   <= dvd_raw;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient    <= neg_q ? -quo : quo;
                        remainder   <= neg_r ? -rem : rem;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divisor_seq.sv
// Directed self-checking bench for divisor_seq at WIDTH=32 and WIDTH=8.
module tb_divisor_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        signed_op = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    logic        start8 = 1'b0;
    logic        signed8 = 1'b0;
    logic [7:0]  dividend8 = '0;
    logic [7:0]  divisor8 = '0;
    logic [7:0]  quotient8;
    logic [7:0]  remainder8;
    logic        busy8;
    logic        done8;
    logic        dbz8;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    divisor_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
        .dividend(dividend), .divisor(divisor), .quotient(quotient),
        .remainder(remainder), .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    divisor_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_op(signed8),
        .dividend(dividend8), .divisor(divisor8), .quotient(quotient8),
        .remainder(remainder8), .busy(busy8), .done(done8), .div_by_zero(dbz8)
    );

    // Called at a negedge; returns at the negedge after the start-sampling edge.
    task automatic do_start(input logic [31:0] a, input logic [31:0] b, input logic s);
        dividend  = a;
        divisor   = b;
        signed_op = s;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges until done is seen (bounded).
    task automatic wait_done(output int n);
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (done) break;
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, output int n);
        @(negedge clk);
        do_start(a, b, s);
        wait_done(n);
    endtask

    task automatic test_reset;
        start = 1'b1;
        start8 = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'h0 || remainder !== 32'h0 || div_by_zero !== 1'b0) begin
            fails++;
            $display("FAIL reset32: busy=%b done=%b q=%h r=%h dbz=%b, required all zero", busy, done, quotient, remainder, div_by_zero);
        end
        tests++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || quotient8 !== 8'h0 || remainder8 !== 8'h0 || dbz8 !== 1'b0) begin
            fails++;
            $display("FAIL reset8: busy=%b done=%b q=%h r=%h dbz=%b, required all zero", busy8, done8, quotient8, remainder8, dbz8);
        end
        rst = 1'b0;
        start = 1'b0;
        start8 = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || busy8 !== 1'b0) begin
            fails++;
            $display("FAIL reset_start_ignored: busy=%b busy8=%b, required 0", busy, busy8);
        end
    endtask

    task automatic test_unsigned_basic;
        @(negedge clk);
        do_start(32'd100, 32'd7, 1'b0);
        for (int k = 0; k <= 32; k++) begin
            tests++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                fails++;
                $display("FAIL basic_busy after E%0d: busy=%b done=%b, required busy=1 done=0", k, busy, done);
            end
            @(negedge clk);
        end
        tests++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_done after E33: done=%b busy=%b, required done=1 busy=0", done, busy);
        end
        tests++;
        if (quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
            fails++;
            $display("FAIL basic_result: q=%0d r=%0d dbz=%b, required 14 2 0", quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || quotient !== 32'd14 || remainder !== 32'd2) begin
            fails++;
            $display("FAIL basic_hold: done=%b q=%0d r=%0d, required 0 14 2", done, quotient, remainder);
        end
    endtask

    task automatic test_signed;
        logic [31:0] av [4] = '{32'hFFFF_FFF9, 32'h0000_0007, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
        logic [31:0] bv [4] = '{32'h0000_0002, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h0000_0002};
        logic        sv [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] qv [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h0000_0003, 32'h7FFF_FFFC};
        logic [31:0] rv [4] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001};
        int n;
        for (int i = 0; i < 4; i++) begin
            run_op(av[i], bv[i], sv[i], n);
            tests++;
            if (n !== 33 || quotient !== qv[i] || remainder !== rv[i] || div_by_zero !== 1'b0) begin
                fails++;
                $display("FAIL signed[%0d]: lat=%0d q=%h r=%h dbz=%b, required 33 %h %h 0",
                         i, n, quotient, remainder, div_by_zero, qv[i], rv[i]);
            end
        end
    endtask

    task automatic test_div_zero_overflow;
        logic [31:0] av [3] = '{32'h0000_0005, 32'hFFFF_FFFB, 32'h8000_0000};
        logic [31:0] bv [3] = '{32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
        logic        sv [3] = '{1'b0, 1'b1, 1'b1};
        logic [31:0] qv [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] rv [3] = '{32'h0000_0005, 32'hFFFF_FFFB, 32'h0000_0000};
        logic        zv [3] = '{1'b1, 1'b1, 1'b0};
        int n;
        for (int i = 0; i < 3; i++) begin
            run_op(av[i], bv[i], sv[i], n);
            tests++;
            if (n !== 33 || quotient !== qv[i] || remainder !== rv[i] || div_by_zero !== zv[i]) begin
                fails++;
                $display("FAIL dbz_ovf[%0d]: lat=%0d q=%h r=%h dbz=%b, required 33 %h %h %b",
                         i, n, quotient, remainder, div_by_zero, qv[i], rv[i], zv[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int n;
        @(negedge clk);
        do_start(32'd50, 32'd5, 1'b0);
        repeat (4) @(negedge clk);
        dividend  = 32'd1000;
        divisor   = 32'd3;
        signed_op = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        tests++;
        if (n !== 28 || done !== 1'b1 || quotient !== 32'd10 || remainder !== 32'd0) begin
            fails++;
            $display("FAIL b2b_first: edges_after_E5=%0d done=%b q=%0d r=%0d, required 28 1 10 0", n, done, quotient, remainder);
        end
        do_start(32'd9, 32'd4, 1'b0);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_no_gap: busy=%b, required 1", busy);
        end
        wait_done(n);
        tests++;
        if (n !== 33 || quotient !== 32'd2 || remainder !== 32'd1 || div_by_zero !== 1'b0) begin
            fails++;
            $display("FAIL b2b_second: lat=%0d q=%0d r=%0d dbz=%b, required 33 2 1 0", n, quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        @(negedge clk);
        do_start(32'hFFFF_FFFF, 32'd1, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'h0 || remainder !== 32'h0 || div_by_zero !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_clear: busy=%b done=%b q=%h r=%h dbz=%b, required all zero", busy, done, quotient, remainder, div_by_zero);
        end
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL reset_mid_no_done: done/busy cycles=%0d, required 0", seen);
        end
    endtask

    task automatic test_width8;
        logic [7:0] av [3] = '{8'hFF, 8'h80, 8'h07};
        logic [7:0] bv [3] = '{8'h10, 8'hFF, 8'h00};
        logic       sv [3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0] qv [3] = '{8'h0F, 8'h80, 8'hFF};
        logic [7:0] rv [3] = '{8'h0F, 8'h00, 8'h07};
        logic       zv [3] = '{1'b0, 1'b0, 1'b1};
        int n;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dividend8 = av[i];
            divisor8  = bv[i];
            signed8   = sv[i];
            start8    = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start8 = 1'b0;
            n = 0;
            while (n < 40) begin
                @(negedge clk);
                n++;
                if (done8) break;
            end
            tests++;
            if (n !== 9 || quotient8 !== qv[i] || remainder8 !== rv[i] || dbz8 !== zv[i]) begin
                fails++;
                $display("FAIL width8[%0d]: lat=%0d q=%h r=%h dbz=%b, required 9 %h %h %b",
                         i, n, quotient8, remainder8, dbz8, qv[i], rv[i], zv[i]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_unsigned_basic;
        test_signed;
        test_div_zero_overflow;
        test_back_to_back;
        test_reset_mid;
        test_width8;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
